// File: rtl/draw_pkg.sv
// Shared types and constants for the frame draw scheduler and its shape drawers.
package draw_pkg;

  localparam int unsigned NUM_SHAPES = 18;
  localparam int unsigned CLEAR_ID   = 17;
  localparam int unsigned COORD_W    = 11;
  localparam int unsigned COLOUR_W   = 3;
  localparam int unsigned ID_W       = $clog2(NUM_SHAPES);

  localparam int unsigned SQUARE_FRAME_1 = 0;
  localparam int unsigned SQUARE_FRAME_2 = 1;
  localparam int unsigned SQUARE_FRAME_3 = 2;
  localparam int unsigned SQUARE_FRAME_4 = 3;
  localparam int unsigned SQUARE_FRAME_5 = 4;
  localparam int unsigned SQUARE_FRAME_6 = 5;
  localparam int unsigned SQUARE_FRAME_7 = 6;
  localparam int unsigned BLOCK_1        = 7;
  localparam int unsigned BLOCK_2        = 8;
  localparam int unsigned BLOCK_3        = 9;
  localparam int unsigned BLOCK_4        = 10;
  localparam int unsigned BLOCK_5        = 11;
  localparam int unsigned SPIKE_1        = 12;
  localparam int unsigned SPIKE_2        = 13;
  localparam int unsigned SPIKE_3        = 14;
  localparam int unsigned SPIKE_4        = 15;
  localparam int unsigned SPIKE_5        = 16;
  localparam int unsigned BLACK_SCREEN   = 17;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StGap
  } state_e;

  function automatic logic [NUM_SHAPES-1:0] slot_bit(input logic [ID_W-1:0] id);
    return NUM_SHAPES'(1) << id;
  endfunction

endpackage

// File: rtl/next_slot_finder.sv
// Finds the lowest enabled slot strictly above cur_id (or from slot 0 when search_all is set).
module next_slot_finder
  import draw_pkg::*;
(
  input  logic [NUM_SHAPES-1:0] mask,
  input  logic [ID_W-1:0]       cur_id,
  input  logic                  search_all,
  output logic                  found,
  output logic [ID_W-1:0]       next_id
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    found   = 1'b0;
    next_id = '0;
    for (int i = NUM_SHAPES - 1; i >= 0; i--) begin
      if (mask[i] && (search_all || (ID_W'(i) > cur_id)) && (i != int'(CLEAR_ID))) begin
        found   = 1'b1;
        next_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Per-frame sequencer sharing one VGA plot port between the shape drawers: clear slot first,
// then enabled slots in ascending order, with a timeout for drawers that never finish.
module frame_draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8191
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic [NUM_SHAPES-1:0]          slot_enable,
  input  logic [NUM_SHAPES-1:0]          draw_done,
  input  logic [NUM_SHAPES*COORD_W-1:0]  shape_x,
  input  logic [NUM_SHAPES*COORD_W-1:0]  shape_y,
  input  logic [NUM_SHAPES*COLOUR_W-1:0] shape_colour,
  output logic [NUM_SHAPES-1:0]          draw_start,
  output logic [COORD_W-1:0]             vga_x,
  output logic [COORD_W-1:0]             vga_y,
  output logic [COLOUR_W-1:0]            vga_colour,
  output logic                           vga_plot,
  output logic [ID_W-1:0]                curr_shape_id,
  output logic                           frame_busy,
  output logic                           frame_overrun,
  output logic                           timeout_err
);

  localparam int unsigned TimerW = $clog2(TIMEOUT);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [NUM_SHAPES-1:0] mask_q, mask_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;

  logic                  next_found;
  logic [ID_W-1:0]       next_id;

  next_slot_finder u_next_slot_finder (
    .mask       (mask_q),
    .cur_id     (id_q),
    .search_all (id_q == ID_W'(CLEAR_ID)),
    .found      (next_found),
    .next_id    (next_id)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      id_q      <= ID_W'(CLEAR_ID);
      mask_q    <= '0;
      timer_q   <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      mask_q    <= mask_d;
      timer_q   <= timer_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    mask_d    = mask_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    // A tick is only accepted from IDLE; anywhere else, including GAP->IDLE, it is an overrun.
    overrun_d = frame_tick && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d = StDraw;
          id_d    = ID_W'(CLEAR_ID);
          mask_d  = slot_enable & ~slot_bit(ID_W'(CLEAR_ID));
          timer_d = '0;
        end
      end
      StDraw: begin
        timer_d = timer_q + 1'b1;
        // Done is ignored on the first DRAW cycle so a stale level from last frame is not taken.
        if ((timer_q != '0) && draw_done[id_q]) begin
          state_d = StGap;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          state_d   = StGap;
          timeout_d = 1'b1;
        end
      end
      StGap: begin
        if (next_found) begin
          state_d = StDraw;
          id_d    = next_id;
          timer_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    draw_start = '0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    if (state_q == StDraw) begin
      draw_start = slot_bit(id_q);
      vga_x      = shape_x[int'(id_q) * COORD_W +: COORD_W];
      vga_y      = shape_y[int'(id_q) * COORD_W +: COORD_W];
      vga_colour = shape_colour[int'(id_q) * COLOUR_W +: COLOUR_W];
    end
  end

  assign vga_plot      = (state_q == StDraw);
  assign frame_busy    = (state_q != StIdle);
  assign curr_shape_id = id_q;
  assign frame_overrun = overrun_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Directed bench: behavioural drawers, start-order scoreboard and per-cycle VGA mux checks.
module tb_frame_draw_scheduler;
  import draw_pkg::*;

  localparam int unsigned TO = 8191;

  logic                           clock;
  logic                           reset;
  logic                           frame_tick;
  logic [NUM_SHAPES-1:0]          slot_enable;
  logic [NUM_SHAPES-1:0]          draw_done;
  logic [NUM_SHAPES*COORD_W-1:0]  shape_x;
  logic [NUM_SHAPES*COORD_W-1:0]  shape_y;
  logic [NUM_SHAPES*COLOUR_W-1:0] shape_colour;
  logic [NUM_SHAPES-1:0]          draw_start;
  logic [COORD_W-1:0]             vga_x;
  logic [COORD_W-1:0]             vga_y;
  logic [COLOUR_W-1:0]            vga_colour;
  logic                           vga_plot;
  logic [ID_W-1:0]                curr_shape_id;
  logic                           frame_busy;
  logic                           frame_overrun;
  logic                           timeout_err;

  frame_draw_scheduler #(.TIMEOUT(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .slot_enable   (slot_enable),
    .draw_done     (draw_done),
    .shape_x       (shape_x),
    .shape_y       (shape_y),
    .shape_colour  (shape_colour),
    .draw_start    (draw_start),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .vga_plot      (vga_plot),
    .curr_shape_id (curr_shape_id),
    .frame_busy    (frame_busy),
    .frame_overrun (frame_overrun),
    .timeout_err   (timeout_err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_q[$];
  int delay[NUM_SHAPES];
  int cnt[NUM_SHAPES];
  int start_cyc[NUM_SHAPES];
  int done_cyc[NUM_SHAPES];
  logic [NUM_SHAPES-1:0] force_done;
  logic [NUM_SHAPES-1:0] prev_start;
  int ovr_cnt = 0;
  int to_cnt = 0;
  int len0 = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int first_set(input logic [NUM_SHAPES-1:0] v);
    for (int i = 0; i < int'(NUM_SHAPES); i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drawer model: done rises delay[i] cycles into a start (0 = never) and holds until start drops.
  initial forever begin
    logic [NUM_SHAPES-1:0] dd;
    @(posedge clock);
    #1;
    for (int i = 0; i < int'(NUM_SHAPES); i++) begin
      if (draw_start[i] === 1'b1) cnt[i]++;
      else cnt[i] = 0;
      if (delay[i] != 0 && cnt[i] == delay[i]) done_cyc[i] = cyc;
      dd[i] = ((delay[i] != 0) && (cnt[i] >= delay[i])) || force_done[i];
    end
    draw_done = dd;
  end

  // Per-cycle checks of the port mux plus the start-order scoreboard.
  initial forever begin
    int idx;
    @(negedge clock);
    if (reset || cyc < 2) begin
      prev_start = draw_start;
      continue;
    end
    check("start_onehot", 32'($countones(draw_start) <= 1), 1);
    check("plot_vs_start", 32'(vga_plot), 32'(|draw_start));
    if (|draw_start) begin
      idx = first_set(draw_start);
      check("cur_id", 32'(curr_shape_id), idx);
      check("vga_x", 32'(vga_x), 32'(shape_x[idx*COORD_W +: COORD_W]));
      check("vga_y", 32'(vga_y), 32'(shape_y[idx*COORD_W +: COORD_W]));
      check("vga_colour", 32'(vga_colour), 32'(shape_colour[idx*COLOUR_W +: COLOUR_W]));
      check("busy_in_draw", 32'(frame_busy), 1);
      if (prev_start == '0) begin
        start_cyc[idx] = cyc;
        if (exp_q.size() == 0) check("start_order", idx, 99);
        else check("start_order", idx, exp_q.pop_front());
      end
    end else begin
      check("vga_idle_zero", 32'({vga_x, vga_y, vga_colour}), 0);
    end
    if (draw_start[0]) len0++;
    if (frame_overrun) ovr_cnt++;
    if (timeout_err) to_cnt++;
    prev_start = draw_start;
  end

  task automatic frame(input logic [NUM_SHAPES-1:0] en);
    slot_enable = en;
    exp_q.push_back(int'(CLEAR_ID));
    for (int i = 0; i < int'(NUM_SHAPES); i++)
      if (en[i] && i != int'(CLEAR_ID)) exp_q.push_back(i);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (frame_busy && n < budget) begin
      step(1);
      n++;
    end
    check(name, 32'(frame_busy), 0);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_start(input string name, input int slot, input int budget);
    int n = 0;
    while (draw_start[slot] !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check(name, 32'(draw_start[slot]), 1);
  endtask

  initial begin
    int o0, t0, n;
    reset = 1'b1;
    frame_tick = 1'b0;
    slot_enable = '0;
    draw_done = '0;
    force_done = '0;
    prev_start = '0;
    for (int i = 0; i < int'(NUM_SHAPES); i++) begin
      delay[i] = 2;
      cnt[i] = 0;
      start_cyc[i] = 0;
      done_cyc[i] = 0;
      shape_x[i*COORD_W +: COORD_W] = COORD_W'(i * 37 + 5);
      shape_y[i*COORD_W +: COORD_W] = COORD_W'(1000 - i * 29);
      shape_colour[i*COLOUR_W +: COLOUR_W] = COLOUR_W'(i + 1);
    end
    step(3);

    // Reset state.
    check("rst_start", 32'(draw_start), 0);
    check("rst_plot", 32'(vga_plot), 0);
    check("rst_id", 32'(curr_shape_id), 17);
    check("rst_busy", 32'(frame_busy), 0);
    check("rst_flags", 32'({frame_overrun, timeout_err}), 0);
    reset = 1'b0;
    step(2);

    // Empty mask: only the clear slot, done on its third cycle.
    delay[17] = 3;
    frame('0);
    check("t1_start17", 32'(draw_start), 32'h20000);
    check("t1_busy", 32'(frame_busy), 1);
    step(2);
    check("t1_start17_t3", 32'(draw_start), 32'h20000);
    step(1);
    check("t1_gap_start", 32'(draw_start), 0);
    check("t1_gap_busy", 32'(frame_busy), 1);
    step(1);
    check("t1_idle_busy", 32'(frame_busy), 0);
    check("t1_drained", exp_q.size(), 0);
    delay[17] = 2;
    step(2);

    // Slots 0 and 7 after the clear slot.
    frame(18'h00081);
    wait_idle("t2_idle", 100);
    check("t2_lat_17_0", start_cyc[0] - done_cyc[17], 2);
    check("t2_lat_0_7", start_cyc[7] - done_cyc[0], 2);
    check("t2_span", start_cyc[7] - start_cyc[17], 6);
    step(2);

    // Slot 12 hangs; slot 13 follows after the timeout.
    delay[12] = 0;
    t0 = to_cnt;
    frame(18'h03000);
    wait_idle("t3_idle", TO + 200);
    check("t3_timeouts", to_cnt - t0, 1);
    check("t3_abandon_span", start_cyc[13] - start_cyc[12], TO + 1);
    delay[12] = 2;
    step(2);

    // Overrun while slot 7 draws, enable change mid-frame, and tick during the final GAP.
    for (int i = 0; i < int'(NUM_SHAPES); i++) delay[i] = 4;
    o0 = ovr_cnt;
    frame(18'h00081);
    slot_enable = '1;
    wait_start("t4_reach7", 7, 100);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    check("t4_ovr_pulse", 32'(frame_overrun), 1);
    n = 0;
    while (draw_start !== '0 && n < 50) begin
      step(1);
      n++;
    end
    check("t4_final_gap", 32'(frame_busy && draw_start == '0), 1);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    check("t4_gap_tick_ignored", 32'(frame_busy), 0);
    check("t4_gap_ovr_pulse", 32'(frame_overrun), 1);
    step(1);
    check("t4_still_idle", 32'(frame_busy), 0);
    check("t4_ovr_count", ovr_cnt - o0, 2);
    check("t4_drained", exp_q.size(), 0);
    slot_enable = '0;
    for (int i = 0; i < int'(NUM_SHAPES); i++) delay[i] = 2;
    step(2);

    // Stale done on slot 0 before the frame; clear bit set in the enable is not redrawn.
    force_done[0] = 1'b1;
    len0 = 0;
    frame(18'h20001);
    wait_idle("t5_idle", 100);
    check("t5_len0", len0, 2);
    force_done[0] = 1'b0;
    step(2);

    // Reset in the middle of slot 7.
    for (int i = 0; i < int'(NUM_SHAPES); i++) delay[i] = 5;
    frame(18'h00081);
    wait_start("t6_reach7", 7, 100);
    check("t6_id7", 32'(curr_shape_id), 7);
    reset = 1'b1;
    step(1);
    check("t6_start", 32'(draw_start), 0);
    check("t6_plot", 32'(vga_plot), 0);
    check("t6_id", 32'(curr_shape_id), 17);
    check("t6_busy", 32'(frame_busy), 0);
    reset = 1'b0;
    exp_q.delete();
    step(3);
    check("t6_stays_idle", 32'(draw_start), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
